// File: rtl/serial_101_pkg.sv
// Shared constants for the serial "101" transmitter: state encoding, default
// sizes and the target bit pattern.
package serial_101_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  // Oldest bit first: hist[1], hist[0], current bit.
  localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/seq_101_track.sv
// Tracks the last two frame bits, flags "101" on the current bit (Mealy) and
// keeps a saturating count of flagged cycles.
module seq_101_track
  import serial_101_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             tx_bit,
  output logic             exp_det,
  output logic [CNT_W-1:0] hits
);

  logic [1:0] hist;

  assign exp_det = bit_valid & (tx_bit == PATTERN[0]) & (hist == PATTERN[2:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      hits <= '0;
    end else if (clr) begin
      hist <= '0;
      hits <= '0;
    end else if (bit_valid) begin
      hist <= {hist[0], tx_bit};
      if (exp_det && (hits != '1)) begin
        hits <= hits + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_101_tx.sv
// Serial "101" pattern transmitter: loads a word on start and shifts it out MSB
// first. Define PARITY_BIT_EN to append an even-parity bit to every frame.
module serial_101_tx
  import serial_101_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             O,
  output logic             valid,
  output logic             exp_det,
  output logic [CNT_W-1:0] hits,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             tx_bit;

  assign accept = ready & start;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
`ifdef PARITY_BIT_EN
      SHIFT:   if (last) state_d = PARITY;
`else
      SHIFT:   if (last) state_d = DONE;
`endif
      PARITY:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

`ifdef PARITY_BIT_EN
  logic par;

  assign valid  = (state == SHIFT) | (state == PARITY);
  assign tx_bit = (state == PARITY) ? par : sreg[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^din;
    end
  end
`else
  assign valid  = (state == SHIFT);
  assign tx_bit = sreg[WIDTH-1];
`endif

  assign O = valid & tx_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        sreg <= din;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
      end
    end
  end

  seq_101_track #(
    .CNT_W(CNT_W)
  ) u_track (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .bit_valid(valid),
    .tx_bit   (tx_bit),
    .exp_det  (exp_det),
    .hits     (hits)
  );

endmodule

// File: tb/tb_serial_101_tx.sv
// Directed bench for serial_101_tx; three instances share stimulus to exercise
// hit-counter widths 4, 2 and 1.
module tb_serial_101_tx;

`ifdef PARITY_BIT_EN
  localparam int FL  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;

  logic       ready, O, valid, exp_det, done;
  logic [3:0] hits;
  logic       ready2, o2, valid2, exp_det2, done2;
  logic [1:0] hits2;
  logic       ready1, o1, valid1, exp_det1, done1;
  logic [0:0] hits1;

  int checks = 0;
  int fails  = 0;

  serial_101_tx #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready), .O(O),
    .valid(valid), .exp_det(exp_det), .hits(hits), .done(done)
  );

  serial_101_tx #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready2), .O(o2),
    .valid(valid2), .exp_det(exp_det2), .hits(hits2), .done(done2)
  );

  serial_101_tx #(.WIDTH(8), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .din(din), .ready(ready1), .O(o1),
    .valid(valid1), .exp_det(exp_det1), .hits(hits1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  // One frame: checks each bit, the done cycle and final hit counts.
  task automatic frame(input string name, input logic [7:0] word, input logic [7:0] det8,
                       input logic par_bit, input logic det9, input int h_np, input int h_p,
                       input bit glitch);
    int   h;
    logic eo, ed;
    h = PAR ? h_p : h_np;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_start: ready=%b required 1", name, ready);
    end
    start = 1'b1;
    din   = word;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (glitch && i == 2) begin
        start = 1'b1;
        din   = ~word;
      end
      if (glitch && i == 3) start = 1'b0;
      eo = (i < 8) ? word[7-i] : par_bit;
      ed = (i < 8) ? det8[7-i] : det9;
      checks++;
      if (valid !== 1'b1 || O !== eo || exp_det !== ed || done !== 1'b0) begin
        fails++;
        $display("FAIL %s bit%0d: valid=%b O=%b exp_det=%b done=%b required 1 %b %b 0",
                 name, i + 1, valid, O, exp_det, done, eo, ed);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || ready !== 1'b0 || O !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle: done=%b valid=%b ready=%b O=%b required 1 0 0 0",
               name, done, valid, ready, O);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || hits !== 4'(h) || hits2 !== 2'((h > 3) ? 3 : h) ||
        hits1 !== 1'((h > 1) ? 1 : h)) begin
      fails++;
      $display("FAIL %s hits: done=%b ready=%b hits=%0d/%0d/%0d required 0 1 %0d/%0d/%0d",
               name, done, ready, hits, hits2, hits1, h, (h > 3) ? 3 : h, (h > 1) ? 1 : h);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (ready !== 1'b1 || O !== 1'b0 || valid !== 1'b0 || exp_det !== 1'b0 ||
        hits !== 4'd0 || done !== 1'b0 || hits2 !== 2'd0 || hits1 !== 1'b0) begin
      fails++;
      $display("FAIL %s: ready=%b O=%b valid=%b exp_det=%b hits=%0d done=%b required 1 0 0 0 0 0",
               name, ready, O, valid, exp_det, hits, done);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    din   = 8'h00;
    #12;
    check_idle("reset_initial");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_idle("reset_mid_idle");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    frame("basic", 8'b1011_0101, 8'b0010_0101, 1'b1, 1'b0, 3, 3, 1'b0);
  endtask

  task automatic test_overlap();
    frame("overlap_aa", 8'b1010_1010, 8'b0010_1010, 1'b0, 1'b0, 3, 3, 1'b0);
    frame("overlap_ab", 8'b1010_1011, 8'b0010_1010, 1'b1, 1'b0, 3, 3, 1'b0);
  endtask

  task automatic test_handshake();
    frame("start_ignored", 8'b1011_0101, 8'b0010_0101, 1'b1, 1'b0, 3, 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    start = 1'b1;
    din   = 8'hA5;
    @(negedge clk);
    checks++;
    if (O !== 1'b1 || valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first_bit: O=%b valid=%b required 1 1", O, valid);
    end
    din = 8'h5A;
    n = 1;
    while (ready !== 1'b1 && n <= 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== FL + 2) begin
      fails++;
      $display("FAIL b2b_period: period=%0d cycles required %0d", n, FL + 2);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || O !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_frame: valid=%b O=%b required 1 0", valid, O);
    end
    n = 0;
    while (ready !== 1'b1 && n <= 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1 || hits !== 4'd2) begin
      fails++;
      $display("FAIL b2b_drain: ready=%b hits=%0d required 1 2", ready, hits);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    start = 1'b1;
    din   = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (valid !== 1'b1 || O !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: valid=%b O=%b required 1 1", valid, O);
    end
    #2 rst = 1'b0;
    #1 check_idle("abort_immediate");
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || valid === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_done: activity after abort=%b required 0", saw_done);
    end
    frame("after_abort", 8'h05, 8'b0000_0001, 1'b0, 1'b0, 1, 1, 1'b0);
  endtask

  task automatic test_no_cross();
    frame("cross_a", 8'b0000_0010, 8'b0000_0000, 1'b1, 1'b1, 0, 1, 1'b0);
    frame("cross_b", 8'b1000_0000, 8'b0000_0000, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_handshake();
    test_back_to_back();
    test_abort();
    test_no_cross();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
